// File: rtl/binary_frame_source_if.sv
// Control/write bus and synthesized video stream of binary_frame_source.
// master: the pattern source itself; slave: the host/finder side.
interface binary_frame_source_if;
    logic        EN;
    logic        WR_EN;
    logic [3:0]  WR_ADDR;
    logic [15:0] WR_DATA;
    logic        VGA_HS;
    logic        VGA_VS;
    logic [15:0] H_CNT;
    logic [15:0] V_CNT;
    logic        BINARY_FLAG;
    logic        FRAME_DONE;

    modport master (
        input  EN, WR_EN, WR_ADDR, WR_DATA,
        output VGA_HS, VGA_VS, H_CNT, V_CNT, BINARY_FLAG, FRAME_DONE
    );

    modport slave (
        output EN, WR_EN, WR_ADDR, WR_DATA,
        input  VGA_HS, VGA_VS, H_CNT, V_CNT, BINARY_FLAG, FRAME_DONE
    );
endinterface

// File: rtl/binary_frame_source.sv
// Binary video pattern source: frame timing plus up to four programmable blobs.
// Optional macro BINARY_FRAME_SOURCE_MOTION_EN makes blobs drift right one pixel per frame.
module binary_frame_source #(
    parameter int unsigned H_ACTIVE = 200,
    parameter int unsigned V_ACTIVE = 100,
    parameter int unsigned H_BLANK  = 1,
    parameter int unsigned V_GAP    = 1
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    binary_frame_source_if.master bus
);
    localparam logic [15:0] H_LAST = 16'(H_ACTIVE - 1);
    localparam logic [15:0] V_LAST = 16'(V_ACTIVE - 1);
    localparam logic [15:0] B_LAST = 16'(H_BLANK - 1);
    localparam logic [15:0] G_LAST = 16'(V_GAP - 1);

    typedef enum logic [2:0] {IDLE, VGAP, LINE, HBLANK, FGAP} state_t;

    state_t      state;
    logic [15:0] cnt;
    logic [15:0] h_cnt, v_cnt;
    logic        hs, vs, flag, done;
    logic [15:0] sh_x0 [4], sh_x1 [4], sh_y0 [4], sh_y1 [4];
    logic [15:0] ac_x0 [4], ac_x1 [4], ac_y0 [4], ac_y1 [4];
    logic [15:0] nh, nv, xe;
    logic        hit, frame_start;
`ifdef BINARY_FRAME_SOURCE_MOTION_EN
    logic [15:0] ofs;
`endif

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int unsigned i = 0; i < 4; i++) begin
                sh_x0[i] <= 16'd1;
                sh_x1[i] <= '0;
                sh_y0[i] <= 16'd1;
                sh_y1[i] <= '0;
            end
        end else if (bus.WR_EN) begin
            case (bus.WR_ADDR[1:0])
                2'd0:    sh_x0[bus.WR_ADDR[3:2]] <= bus.WR_DATA;
                2'd1:    sh_x1[bus.WR_ADDR[3:2]] <= bus.WR_DATA;
                2'd2:    sh_y0[bus.WR_ADDR[3:2]] <= bus.WR_DATA;
                default: sh_y1[bus.WR_ADDR[3:2]] <= bus.WR_DATA;
            endcase
        end
    end

    // Outputs are registered, so the blob test looks at the pixel being entered.
    always_comb begin
        nh = h_cnt;
        nv = v_cnt;
        case (state)
            LINE:    nh = h_cnt + 16'd1;
            HBLANK:  begin nh = '0; nv = v_cnt + 16'd1; end
            VGAP:    begin nh = '0; nv = '0; end
            default: ;
        endcase
`ifdef BINARY_FRAME_SOURCE_MOTION_EN
        xe = (nh >= ofs) ? nh - ofs : nh + 16'(H_ACTIVE) - ofs;
`else
        xe = nh;
`endif
        hit = 1'b0;
        for (int unsigned b = 0; b < 4; b++) begin
            if (ac_x0[b] <= xe && xe <= ac_x1[b] && ac_y0[b] <= nv && nv <= ac_y1[b])
                hit = 1'b1;
        end
    end

    assign frame_start = bus.EN && ((state == IDLE) || (state == FGAP && cnt == G_LAST));

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= IDLE;
            cnt   <= '0;
            h_cnt <= '0;
            v_cnt <= '0;
            hs    <= 1'b0;
            vs    <= 1'b0;
            flag  <= 1'b0;
            done  <= 1'b0;
            for (int unsigned i = 0; i < 4; i++) begin
                ac_x0[i] <= 16'd1;
                ac_x1[i] <= '0;
                ac_y0[i] <= 16'd1;
                ac_y1[i] <= '0;
            end
`ifdef BINARY_FRAME_SOURCE_MOTION_EN
            ofs <= '0;
`endif
        end else begin
            case (state)
                IDLE: ;
                VGAP: begin
                    if (cnt == G_LAST) begin
                        state <= LINE;
                        hs    <= 1'b1;
                        vs    <= 1'b1;
                        flag  <= hit;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                LINE: begin
                    if (h_cnt == H_LAST) begin
                        state <= HBLANK;
                        cnt   <= '0;
                        hs    <= 1'b0;
                        flag  <= 1'b0;
                    end else begin
                        h_cnt <= nh;
                        flag  <= hit;
                    end
                end
                HBLANK: begin
                    if (cnt != B_LAST) begin
                        cnt <= cnt + 16'd1;
                    end else if (v_cnt == V_LAST) begin
                        state <= FGAP;
                        cnt   <= '0;
                        vs    <= 1'b0;
                        done  <= (V_GAP == 1);
                    end else begin
                        state <= LINE;
                        h_cnt <= nh;
                        v_cnt <= nv;
                        hs    <= 1'b1;
                        flag  <= hit;
                    end
                end
                FGAP: begin
                    if (cnt == G_LAST) begin
                        state <= IDLE;
                        done  <= 1'b0;
`ifdef BINARY_FRAME_SOURCE_MOTION_EN
                        ofs <= (ofs == H_LAST) ? '0 : ofs + 16'd1;
`endif
                    end else begin
                        cnt  <= cnt + 16'd1;
                        done <= (cnt + 16'd1 == G_LAST);
                    end
                end
                default: state <= IDLE;
            endcase

            // Frame entry overrides the IDLE fall-through of a finishing FGAP.
            if (frame_start) begin
                state <= VGAP;
                cnt   <= '0;
                h_cnt <= '0;
                v_cnt <= '0;
                for (int unsigned i = 0; i < 4; i++) begin
                    ac_x0[i] <= sh_x0[i];
                    ac_x1[i] <= sh_x1[i];
                    ac_y0[i] <= sh_y0[i];
                    ac_y1[i] <= sh_y1[i];
                end
            end
        end
    end

    assign bus.VGA_HS      = hs;
    assign bus.VGA_VS      = vs;
    assign bus.H_CNT       = h_cnt;
    assign bus.V_CNT       = v_cnt;
    assign bus.BINARY_FLAG = flag;
    assign bus.FRAME_DONE  = done;

`ifndef SYNTHESIS
    param_legal: assert property (@(posedge CLK) (H_BLANK >= 1) && (V_GAP >= 1));
`endif
endmodule

// File: tb/tb_binary_frame_source.sv
// Self-checking bench for binary_frame_source against a frame-level reference model.
// Honours BINARY_FRAME_SOURCE_MOTION_EN to model the drifting-blob build.
module tb_binary_frame_source;
    localparam int HA = 200;
    localparam int VA = 100;
    localparam int HB = 1;
    localparam int VG = 1;
    localparam int L  = HA + HB;
    localparam int P  = VG + VA * L + VG;

    logic CLK = 1'b0;
    logic RESET_N = 1'b0;

    binary_frame_source_if bus ();

    binary_frame_source #(
        .H_ACTIVE(HA),
        .V_ACTIVE(VA),
        .H_BLANK (HB),
        .V_GAP   (VG)
    ) dut (
        .CLK    (CLK),
        .RESET_N(RESET_N),
        .bus    (bus)
    );

    always #5 CLK = ~CLK;

    int compared = 0;
    int mismatched = 0;

    int m_sh_x0 [4], m_sh_x1 [4], m_sh_y0 [4], m_sh_y1 [4];
    int m_ac_x0 [4], m_ac_x1 [4], m_ac_y0 [4], m_ac_y1 [4];
    int m_ofs;

    function automatic void m_reset();
        for (int b = 0; b < 4; b++) begin
            m_sh_x0[b] = 1; m_sh_x1[b] = 0; m_sh_y0[b] = 1; m_sh_y1[b] = 0;
            m_ac_x0[b] = 1; m_ac_x1[b] = 0; m_ac_y0[b] = 1; m_ac_y1[b] = 0;
        end
        m_ofs = 0;
    endfunction

    function automatic void m_write(input logic [3:0] a, input logic [15:0] d);
        int b;
        b = int'(a[3:2]);
        case (a[1:0])
            2'd0:    m_sh_x0[b] = int'(d);
            2'd1:    m_sh_x1[b] = int'(d);
            2'd2:    m_sh_y0[b] = int'(d);
            default: m_sh_y1[b] = int'(d);
        endcase
    endfunction

    function automatic void m_load();
        for (int b = 0; b < 4; b++) begin
            m_ac_x0[b] = m_sh_x0[b]; m_ac_x1[b] = m_sh_x1[b];
            m_ac_y0[b] = m_sh_y0[b]; m_ac_y1[b] = m_sh_y1[b];
        end
    endfunction

    function automatic void m_frame_done();
        m_ofs = (m_ofs + 1) % HA;
    endfunction

    function automatic bit lit(input int h, input int v);
        int xe;
        xe = h;
`ifdef BINARY_FRAME_SOURCE_MOTION_EN
        xe = (h - m_ofs + HA) % HA;
`endif
        for (int b = 0; b < 4; b++)
            if (m_ac_x0[b] <= xe && xe <= m_ac_x1[b] && m_ac_y0[b] <= v && v <= m_ac_y1[b])
                return 1'b1;
        return 1'b0;
    endfunction

    // Expected {HS, VS, H_CNT, V_CNT, BINARY_FLAG, FRAME_DONE} at cycle t of a frame
    // (t=0 is the first VS-low cycle); t >= P gives the held post-frame state.
    function automatic logic [35:0] expect_at(input int t);
        logic hs, vs, fl, dn;
        int h, v, r;
        hs = 0; vs = 0; fl = 0; dn = 0; h = 0; v = 0;
        if (t < VG) begin
            h = 0;
        end else if (t < VG + VA * L) begin
            r  = t - VG;
            v  = r / L;
            vs = 1;
            if (r % L < HA) begin
                hs = 1;
                h  = r % L;
                fl = lit(h, v);
            end else begin
                h = HA - 1;
            end
        end else begin
            h  = HA - 1;
            v  = VA - 1;
            dn = (t == P - 1);
        end
        return {hs, vs, 16'(h), 16'(v), fl, dn};
    endfunction

    function automatic logic [35:0] observed();
        return {bus.VGA_HS, bus.VGA_VS, bus.H_CNT, bus.V_CNT, bus.BINARY_FLAG, bus.FRAME_DONE};
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_write(input logic [3:0] a, input logic [15:0] d);
        bus.WR_EN   = 1'b1;
        bus.WR_ADDR = a;
        bus.WR_DATA = d;
        m_write(a, d);
    endtask

    task automatic test_reset();
        logic [35:0] obs;
        bus.EN = 1'b0;
        RESET_N = 1'b0;
        repeat (3) step();
        obs = observed();
        compared++;
        if (obs !== 36'd0) begin
            mismatched++;
            $display("FAIL reset_hold got=%h want=%h", obs, 36'd0);
        end
        RESET_N = 1'b1;
        for (int i = 0; i < 50; i++) begin
            obs = observed();
            compared++;
            if (obs !== 36'd0) begin
                mismatched++;
                $display("FAIL idle_en0 cycle=%0d got=%h want=%h", i, obs, 36'd0);
            end
            step();
        end
    endtask

    // Default blobs, EN dropped mid-frame: the frame completes, then IDLE holds.
    task automatic test_default_frame();
        logic [35:0] obs, exp;
        bus.EN = 1'b1;
        m_load();
        step();
        for (int t = 0; t < P; t++) begin
            obs = observed();
            exp = expect_at(t);
            compared++;
            if (obs !== exp) begin
                mismatched++;
                $display("FAIL frame_a t=%0d got=%h want=%h", t, obs, exp);
            end
            if (t == 5000) bus.EN = 1'b0;
            step();
        end
        m_frame_done();
        for (int i = 0; i < 10; i++) begin
            obs = observed();
            exp = expect_at(P);
            compared++;
            if (obs !== exp) begin
                mismatched++;
                $display("FAIL idle_after_frame cycle=%0d got=%h want=%h", i, obs, exp);
            end
            step();
        end
    endtask

    task automatic test_blob_frames();
        logic [35:0] obs, exp;
        logic [19:0] init_tab [$];
        logic [19:0] mid_q [$];
        logic [19:0] w;
        int lit_cnt, want_cnt, x0, y0;

        init_tab = '{{4'h0, 16'd10}, {4'h1, 16'd12}, {4'h2, 16'd5}, {4'h3, 16'd6},
                     {4'h4, 16'd150}, {4'h5, 16'd150}, {4'h6, 16'd90}, {4'h7, 16'd99}};
        want_cnt = 16;
`ifdef BINARY_FRAME_SOURCE_MOTION_EN
        init_tab.push_back({4'hC, 16'd198});
        init_tab.push_back({4'hD, 16'd199});
        init_tab.push_back({4'hE, 16'd0});
        init_tab.push_back({4'hF, 16'd0});
        want_cnt = 18;
`endif
        foreach (init_tab[i]) begin
            set_write(init_tab[i][19:16], init_tab[i][15:0]);
            step();
        end
        bus.WR_EN = 1'b0;

        // Mid-frame rewrites: visible only from the next frame.
        mid_q = '{{4'h0, 16'd50}, {4'h1, 16'd50}, {4'h2, 16'd50}, {4'h3, 16'd50}};
        x0 = int'($urandom_range(0, 190));
        y0 = int'($urandom_range(0, 2));
        mid_q.push_back({4'h8, 16'(x0)});
        mid_q.push_back({4'h9, 16'(x0 + int'($urandom_range(0, 5)))});
        mid_q.push_back({4'hA, 16'(y0)});
        mid_q.push_back({4'hB, 16'(y0 + int'($urandom_range(0, 3)))});
`ifndef BINARY_FRAME_SOURCE_MOTION_EN
        mid_q.push_back({4'hC, 16'($urandom_range(0, 250))});
        mid_q.push_back({4'hD, 16'($urandom_range(0, 250))});
        mid_q.push_back({4'hE, 16'($urandom_range(0, 120))});
        mid_q.push_back({4'hF, 16'($urandom_range(0, 120))});
`endif

        bus.EN = 1'b1;
        m_load();
        step();
        lit_cnt = 0;
        for (int t = 0; t < P; t++) begin
            obs = observed();
            exp = expect_at(t);
            compared++;
            if (obs !== exp) begin
                mismatched++;
                $display("FAIL frame_b t=%0d got=%h want=%h", t, obs, exp);
            end
            if (bus.BINARY_FLAG === 1'b1) lit_cnt++;
            bus.WR_EN = 1'b0;
            if (t >= VG + 30 * L && mid_q.size() > 0) begin
                w = mid_q.pop_front();
                set_write(w[19:16], w[15:0]);
            end
            if (t == P - 1) begin
                // Write coinciding with the shadow->active copy: shadow only.
                m_frame_done();
                m_load();
                set_write(4'h9, 16'd199);
            end
            step();
        end
        compared++;
        if (lit_cnt !== want_cnt) begin
            mismatched++;
            $display("FAIL blob_pixel_count got=%0d want=%0d", lit_cnt, want_cnt);
        end

        for (int t = 0; t < P; t++) begin
            obs = observed();
            exp = expect_at(t);
            compared++;
            if (obs !== exp) begin
                mismatched++;
                $display("FAIL frame_c t=%0d got=%h want=%h", t, obs, exp);
            end
            bus.WR_EN = 1'b0;
            if (t == P - 1) begin
                m_frame_done();
                m_load();
            end
            step();
        end
    endtask

    task automatic test_mid_frame_reset();
        logic [35:0] obs, exp;
        int t_rst;
        t_rst = VG + 40 * L + 77;
        for (int t = 0; t <= t_rst; t++) begin
            obs = observed();
            exp = expect_at(t);
            compared++;
            if (obs !== exp) begin
                mismatched++;
                $display("FAIL frame_d t=%0d got=%h want=%h", t, obs, exp);
            end
            if (t < t_rst) step();
        end
        RESET_N = 1'b0;
        #1;
        obs = observed();
        compared++;
        if (obs !== 36'd0) begin
            mismatched++;
            $display("FAIL async_reset got=%h want=%h", obs, 36'd0);
        end
        m_reset();
        #2;
        RESET_N = 1'b1;
        m_load();
        step();
        for (int t = 0; t < VG + 4 * L; t++) begin
            obs = observed();
            exp = expect_at(t);
            compared++;
            if (obs !== exp) begin
                mismatched++;
                $display("FAIL fresh_frame t=%0d got=%h want=%h", t, obs, exp);
            end
            step();
        end
        bus.EN = 1'b0;
    endtask

    initial begin
        bus.EN      = 1'b0;
        bus.WR_EN   = 1'b0;
        bus.WR_ADDR = '0;
        bus.WR_DATA = '0;
        m_reset();
        test_reset();
        test_default_frame();
        test_blob_frames();
        test_mid_frame_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
